gpreg_sb: RTL and testbench
===========================

Name: gpreg_sb

Overview:
- Parametrised general-purpose register file: next generation of the core's single-write, dual-read GPR block.
- Adds configurable data width, register count, read-port count, synchronous reset-to-zero, optional write-to-read bypass, and a per-register pending scoreboard with a registered pending count.
- Sits between decode (read/issue) and writeback (write) in the pipelined core.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W registers.
- NR_READ, 2, number of combinational read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  writeback valid.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- rd_addr  in  NR_READ*ADDR_W  read addresses; port i occupies [i*ADDR_W +: ADDR_W].
- rd_data  out  NR_READ*DATA_W  read data; port i occupies [i*DATA_W +: DATA_W].
- rd_busy  out  NR_READ  pending bit of each addressed register, after bypass adjustment.
- iss_en  in  1  issue valid; marks iss_addr pending.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  clears all pending bits.
- busy_vec  out  2**ADDR_W  registered pending bits, bit 0 always 0.
- pend_cnt  out  ADDR_W+1  registered count of set pending bits.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state: while rst_n=0, all registers = 0, busy_vec = 0, pend_cnt = 0. rd_data follows the zeroed registers combinationally.
- Write: at posedge, if wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are discarded.
- Read: combinational, zero latency. Address 0 always returns 0 and rd_busy=0.
- Bypass, BYPASS=1: if wr_en=1 and wr_addr==rd_addr[i]!=0, rd_data[i]=wr_data and rd_busy[i]=0. Otherwise rd_data[i]=reg[rd_addr[i]] and rd_busy[i]=busy_vec[rd_addr[i]].
- Bypass, BYPASS=0: no forwarding. rd_busy[i]=busy_vec[rd_addr[i]]. The new value is visible the cycle after the write.
- Pending update per register r (r!=0), in priority order at posedge:
  1. flush=1 -> 0.
  2. iss_en=1 and iss_addr==r -> 1. Issue beats a same-cycle write to the same r: a new producer is outstanding.
  3. wr_en=1 and wr_addr==r -> 0.
  4. Otherwise hold.
- Other pending rules:
  - Writes are still performed during flush.
  - iss_en with iss_addr=0 has no effect.
  - Issue to an already-pending register leaves it pending; there is no nesting count.
- pend_cnt: registered; equals popcount of busy_vec at all times. Update it incrementally (+1, -1, 0, or reset to 0 on flush) in the same cycle busy_vec updates. It never exceeds 2**ADDR_W-1.
- Simultaneous write and read of the same address with BYPASS=0: the read returns the old value.
- Reset asserted mid-operation: all state clears immediately, independent of clk. First updates occur on the first posedge after rst_n rises.

Decomposition:
- Shared package gpreg_pkg: default DATA_W/ADDR_W constants, REG_ZERO address constant, and a popcount-width helper function.
- One sub-module, gpreg_sb_score: the pending-bit vector plus the pend_cnt counter. Inputs: iss_en/iss_addr, wr_en/wr_addr, flush. Outputs: busy_vec, pend_cnt.
- The top level holds the data array and the read/bypass muxes.

Test Plan:
- Reset then read all: rst_n=0 -> rd_data=0 on every port for addresses 0..31; busy_vec=0; pend_cnt=0.
- Write/readback: write 0xDEADBEEF to x5, next cycle rd_addr[0]=5 -> 0xDEADBEEF. Write 0x1234 to x0 -> x0 still reads 0.
- Bypass: BYPASS=1, wr_en with x7=0xA5A5A5A5 and rd_addr[1]=7 in the same cycle -> rd_data[1]=0xA5A5A5A5, rd_busy[1]=0. With BYPASS=0 -> old value 0.
- Scoreboard: issue x3, then x4 -> pend_cnt=2. Write x3 -> pend_cnt=1, busy_vec[3]=0. Same-cycle issue and write of x4 -> busy_vec[4]=1, pend_cnt=1.
- Flush and reset mid-op: pend x1..x10 (pend_cnt=10), flush with a concurrent iss_en on x11 -> busy_vec=0, pend_cnt=0. Then pend x2 and drop rst_n between edges -> busy_vec=0 immediately.

Source files
------------

// File: rtl/gpreg_pkg.sv
// Shared constants and helpers for the gpreg_sb register file and its pending scoreboard.
package gpreg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Bits needed to hold a population count of n flags (0..n inclusive).
    function automatic int pop_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gpreg_sb_score.sv
// Per-register pending scoreboard: one busy bit per register plus an incrementally
// maintained count of set bits. Register 0 can never become pending.
module gpreg_sb_score
    import gpreg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   flush,
    output logic [2**ADDR_W-1:0]   busy_vec,
    output logic [ADDR_W:0]        pend_cnt
);

    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = pop_w(NREG);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [NREG-1:0]  busy_d, busy_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             iss_set;
    logic             wr_clr;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        iss_set = iss_en && (iss_addr != ZERO_A);
        // A same-cycle issue to the written register wins: a newer producer is outstanding.
        wr_clr  = wr_en && (wr_addr != ZERO_A) && !(iss_set && (iss_addr == wr_addr));

        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_clr) begin
                busy_d[wr_addr] = 1'b0;
                if (busy_q[wr_addr]) cnt_d = cnt_d - CNT_ONE;
            end
            if (iss_set) begin
                busy_d[iss_addr] = 1'b1;
                if (!busy_q[iss_addr]) cnt_d = cnt_d + CNT_ONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign pend_cnt = cnt_q;

endmodule

// File: rtl/gpreg_sb.sv
// Parametrised single-write, multi-read general-purpose register file with optional
// write-to-read bypass and a per-register pending scoreboard. Register 0 reads as zero.
module gpreg_sb
    import gpreg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NR_READ = 2,
    parameter int BYPASS  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [NR_READ*ADDR_W-1:0]   rd_addr,
    output logic [NR_READ*DATA_W-1:0]   rd_data,
    output logic [NR_READ-1:0]          rd_busy,
    input  logic                        iss_en,
    input  logic [ADDR_W-1:0]           iss_addr,
    input  logic                        flush,
    output logic [2**ADDR_W-1:0]        busy_vec,
    output logic [ADDR_W:0]             pend_cnt
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] regs_q [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != ZERO_A)) regs_d[wr_addr] = wr_data;
    end

    // NOTE: the array is reset because the architecture requires zeroed registers out of reset;
    // plain storage arrays without that requirement are normally left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    gpreg_sb_score #(
        .ADDR_W (ADDR_W)
    ) u_score (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy_vec (busy_vec),
        .pend_cnt (pend_cnt)
    );

    // Slot 0 is never written and its busy bit never set, so address 0 needs no special case.
    for (genvar i = 0; i < NR_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit = (BYPASS != 0) && wr_en && (wr_addr == ra) && (ra != ZERO_A);

        assign rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : regs_q[ra];
        assign rd_busy[i]                  = hit ? 1'b0    : busy_vec[ra];
    end

endmodule

// File: tb/tb_gpreg_sb.sv
// Scoreboard bench for gpreg_sb: a bypassing and a non-bypassing instance share stimulus;
// expectations come from a behavioural register/pending model and fixed test-plan values.
module tb_gpreg_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic [31:0] busy_vec, nb_busy_vec;
    logic [5:0]  pend_cnt, nb_pend_cnt;

    always #5 clk = ~clk;

    gpreg_sb #(.DATA_W(32), .ADDR_W(5), .NR_READ(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec), .pend_cnt(pend_cnt)
    );

    gpreg_sb #(.DATA_W(32), .ADDR_W(5), .NR_READ(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_vec(nb_busy_vec), .pend_cnt(nb_pend_cnt)
    );

    typedef enum {OBS_RD0, OBS_RD1, OBS_BSY0, OBS_BSY1, OBS_NB_RD1, OBS_NB_BSY1,
                  OBS_BVEC, OBS_PCNT, OBS_NB_PCNT} obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] observe(input obs_e s);
        case (s)
            OBS_RD0:     return 64'(rd_data[31:0]);
            OBS_RD1:     return 64'(rd_data[63:32]);
            OBS_BSY0:    return 64'(rd_busy[0]);
            OBS_BSY1:    return 64'(rd_busy[1]);
            OBS_NB_RD1:  return 64'(nb_rd_data[63:32]);
            OBS_NB_BSY1: return 64'(nb_rd_busy[1]);
            OBS_BVEC:    return 64'(busy_vec);
            OBS_PCNT:    return 64'(pend_cnt);
            OBS_NB_PCNT: return 64'(nb_pend_cnt);
            default:     return '0;
        endcase
    endfunction

    task automatic push(input string tag, input obs_e sel, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    function automatic int popc(input logic [31:0] v);
        int n = 0;
        for (int b = 0; b < 32; b++) n += int'(v[b]);
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && wr_en && (wr_addr == ra)) return wr_data;
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 1'b0;
        if (byp && wr_en && (wr_addr == ra)) return 1'b0;
        return m_busy[ra];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
    endtask

    task automatic model_step();
        if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
        if (flush) begin
            m_busy = '0;
        end else begin
            if (wr_en && wr_addr != 5'd0) m_busy[wr_addr] = 1'b0;
            if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic push_reads();
        logic [4:0] ra0, ra1;
        ra0 = rd_addr[4:0];
        ra1 = rd_addr[9:5];
        push("rd0",     OBS_RD0,     64'(exp_data(ra0, 1'b1)));
        push("rd1",     OBS_RD1,     64'(exp_data(ra1, 1'b1)));
        push("bsy0",    OBS_BSY0,    64'(exp_busy(ra0, 1'b1)));
        push("bsy1",    OBS_BSY1,    64'(exp_busy(ra1, 1'b1)));
        push("nb_rd1",  OBS_NB_RD1,  64'(exp_data(ra1, 1'b0)));
        push("nb_bsy1", OBS_NB_BSY1, 64'(exp_busy(ra1, 1'b0)));
    endtask

    task automatic push_state();
        push("busy_vec",    OBS_BVEC,    64'(m_busy));
        push("pend_cnt",    OBS_PCNT,    64'(popc(m_busy)));
        push("nb_pend_cnt", OBS_NB_PCNT, 64'(popc(m_busy)));
    endtask

    // Entered and left at posedge+1: reads checked at negedge, registered state after the edge.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic fl,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
        rd_addr  = {ra1, ra0};
        push_reads();
        @(negedge clk);
        drain();
        @(posedge clk);
        model_step();
        #1;
        push_state();
        drain();
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, ra0, ra1);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        model_reset();

        // Reset: every address reads zero on both ports.
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            push("rst_rd0", OBS_RD0, 64'd0);
            push("rst_rd1", OBS_RD1, 64'd0);
            push("rst_nb_rd1", OBS_NB_RD1, 64'd0);
            drain();
        end
        push("rst_busy_vec", OBS_BVEC, 64'd0);
        push("rst_pend_cnt", OBS_PCNT, 64'd0);
        drain();

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write / readback, and writes to x0 discarded.
        push("x5_bypass", OBS_RD0, 64'h0000_0000_DEAD_BEEF);
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        push("x5_readback", OBS_RD0, 64'h0000_0000_DEAD_BEEF);
        idle(5'd5, 5'd5);
        cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        push("x0_zero", OBS_RD0, 64'd0);
        idle(5'd0, 5'd5);

        // Bypass vs. no bypass on a pending register.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
        push("byp_rd1",     OBS_RD1,     64'h0000_0000_A5A5_A5A5);
        push("byp_bsy1",    OBS_BSY1,    64'd0);
        push("nobyp_rd1",   OBS_NB_RD1,  64'd0);
        push("nobyp_bsy1",  OBS_NB_BSY1, 64'd1);
        cycle(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        push("nobyp_next",  OBS_NB_RD1,  64'h0000_0000_A5A5_A5A5);
        idle(5'd7, 5'd7);

        // Scoreboard set / clear / issue-beats-write / re-issue.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd4);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd4);
        push("sb_cnt2", OBS_PCNT, 64'd2);
        drain();
        cycle(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
        push("sb_cnt1", OBS_PCNT, 64'd1);
        push("sb_vec_x4", OBS_BVEC, 64'h10);
        drain();
        cycle(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 1'b0, 5'd4, 5'd4);
        push("iss_beats_wr_vec", OBS_BVEC, 64'h10);
        push("iss_beats_wr_cnt", OBS_PCNT, 64'd1);
        drain();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd3);
        push("reissue_cnt", OBS_PCNT, 64'd1);
        drain();

        // Pend x1..x10, then flush with a concurrent issue and write.
        for (int r = 1; r <= 10; r++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0, 5'(r), 5'd4);
        push("pend10", OBS_PCNT, 64'd10);
        drain();
        cycle(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd11, 1'b1, 5'd6, 5'd11);
        push("flush_vec", OBS_BVEC, 64'd0);
        push("flush_cnt", OBS_PCNT, 64'd0);
        drain();
        push("flush_wr_kept", OBS_RD0, 64'h66);
        idle(5'd6, 5'd11);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        push("iss_x0_cnt", OBS_PCNT, 64'd0);
        drain();

        // Reset dropped between edges clears state immediately.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd5, 5'd2);
        push("pend_x2", OBS_BVEC, 64'h4);
        drain();
        wr_en   = 1'b0;
        iss_en  = 1'b0;
        flush   = 1'b0;
        rd_addr = {5'd2, 5'd5};
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push("midrst_vec", OBS_BVEC, 64'd0);
        push("midrst_cnt", OBS_PCNT, 64'd0);
        push("midrst_rd0", OBS_RD0, 64'd0);
        push("midrst_bsy1", OBS_BSY1, 64'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_state();
        drain();
        cycle(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd12, 1'b0, 5'd9, 5'd12);
        idle(5'd9, 5'd12);

        // Random mix against the model.
        for (int n = 0; n < 60; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 15) == 0),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
